pio_in_reader: RTL

//  CPU-side input port, the read-direction companion of the LED/GPIO output port.

---
 rtl/pio_in_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pio_in_reader.sv
// Purpose: CPU read port for slide switches and push-buttons, with synchronised switches,
//          debounced buttons, sticky press capture, maskable interrupt and a 4-entry register map.
// Latency: pins reach sw_s after 2 cycles and btn_db after 2 + DB_CNT; reads return data 1 cycle after RD.
// Backpressure: none; every RD/WR strobe is accepted in the cycle it is presented.
module pio_in_reader #(
  parameter int SW_W   = 16,
  parameter int BTN_W  = 5,
  parameter int DB_CNT = 1000,
  parameter int CNT_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RD,
  input  logic             WR,
  input  logic [1:0]       ADDR,
  input  logic [31:0]      PData_in,
  input  logic [SW_W-1:0]  SW,
  input  logic [BTN_W-1:0] BTN,
  output logic [31:0]      PData_out,
  output logic             rd_valid,
  output logic             irq
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CNT - 1);

  logic [SW_W-1:0]  sw_m;
  logic [SW_W-1:0]  sw_s;
  logic [BTN_W-1:0] btn_m;
  logic [BTN_W-1:0] btn_s;
  logic [BTN_W-1:0] btn_db;
  logic [CNT_W-1:0] cnt [BTN_W];
  logic [BTN_W-1:0] rise;
  logic [BTN_W-1:0] edge_cap;
  logic [BTN_W-1:0] mask;
  logic [31:0]      rd_data;
  logic             clr_cap;
  logic             mask_we;

  // Upper write-data bits have no register behind them.
  logic unused_pdata;
  assign unused_pdata = ^PData_in[31:BTN_W];

  assign clr_cap = RD && (ADDR == 2'd1);
  assign mask_we = WR && (ADDR == 2'd2);

  // Two-flop synchronisers for the asynchronous switch and button pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_m  <= '0;
      sw_s  <= '0;
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      sw_m  <= SW;
      sw_s  <= sw_m;
      btn_m <= BTN;
      btn_s <= btn_m;
    end
  end

  // Per-button debounce: accept a new level only after DB_CNT consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= '0;
      for (int i = 0; i < BTN_W; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_W; i++) begin
        if (btn_s[i] == btn_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_MAX) begin
          btn_db[i] <= btn_s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is recognised on the very edge btn_db goes 0 -> 1, so capture lines up with btn_db.
  always_comb begin
    rise = '0;
    for (int i = 0; i < BTN_W; i++) begin
      rise[i] = btn_s[i] & ~btn_db[i] & (cnt[i] == DB_MAX);
    end
  end

  // Sticky press capture; a new press in the clearing cycle survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (clr_cap ? '0 : edge_cap) | rise;
    end
  end

  // Read mux over current (pre-update) register state.
  always_comb begin
    rd_data = '0;
    case (ADDR)
      2'd0: begin
        rd_data[SW_W-1:0]      = sw_s;
        rd_data[SW_W+:BTN_W]   = btn_db;
      end
      2'd1:    rd_data[BTN_W-1:0] = edge_cap;
      2'd2:    rd_data[BTN_W-1:0] = mask;
      default: rd_data = '0;
    endcase
  end

  // Bus side: registered read data and strobe, mask register and interrupt level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PData_out <= '0;
      rd_valid  <= 1'b0;
      mask      <= '0;
      irq       <= 1'b0;
    end else begin
      rd_valid <= RD;
      if (RD) PData_out <= rd_data;
      if (mask_we) mask <= PData_in[BTN_W-1:0];
      irq <= |(edge_cap & mask);
    end
  end

endmodule
